// File: rtl/issue_queue_if.sv
// Rename/EXE-facing bundle of the out-of-order issue queue.
// Latency: wires only; the queue registers its outputs internally.
// Backpressure: issue_halt is driven by the queue and read by rename.
interface issue_queue_if #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 89,
  parameter int PREG_W  = 6,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) ();
  logic               STALL;
  logic               FLUSH;
  logic               alloc;
  logic [ENTRY_W-1:0] alloc_entry;
  logic [63:0]        busy;
  logic               wakeup_flag;
  logic [PREG_W-1:0]  wakeup_reg;
  logic               issue_halt;
  logic               issue_valid;
  logic [ENTRY_W-1:0] issue_entry;
  logic [CNT_W-1:0]   count;
  logic               overflow_err;

  // Rename/EXE side drives the control and allocation signals.
  modport master (
    output STALL, FLUSH, alloc, alloc_entry, busy, wakeup_flag, wakeup_reg,
    input  issue_halt, issue_valid, issue_entry, count, overflow_err
  );

  // The queue consumes them and returns issue results and status.
  modport slave (
    input  STALL, FLUSH, alloc, alloc_entry, busy, wakeup_flag, wakeup_reg,
    output issue_halt, issue_valid, issue_entry, count, overflow_err
  );
endinterface

// File: rtl/issue_queue.sv
// Compacting age-ordered issue queue: issues the oldest slot with both sources ready.
// Latency: alloc->issue >= 1 edge; wakeup->issue 1 edge (0 with ISSUE_QUEUE_WAKEUP_BYPASS_EN).
// Backpressure: issue_halt at count >= DEPTH-1; alloc into a full queue without issue sets sticky overflow_err.
module issue_queue #(
  parameter int DEPTH   = 16,
  parameter int ENTRY_W = 89,
  parameter int PREG_W  = 6
) (
  input logic          CLK,
  input logic          RESET,
  issue_queue_if.slave q
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] HALT_CNT = CNT_W'(DEPTH - 1);

  logic [ENTRY_W-1:0] entry_q [DEPTH];
  logic [ENTRY_W-1:0] entry_d [DEPTH];
  logic [DEPTH-1:0]   rdya_q, rdya_d, rdyb_q, rdyb_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               issue_valid_q, issue_valid_d;
  logic [ENTRY_W-1:0] issue_entry_q, issue_entry_d;
  logic               overflow_q, overflow_d;

  logic [DEPTH-1:0]   wake_a, wake_b, eff_a, eff_b;
  logic               sel_vld;
  logic [IDX_W-1:0]   sel_idx;
  logic [CNT_W-1:0]   cnt_after;
  logic [PREG_W-1:0]  new_a, new_b;
  logic               cap_a, cap_b;

  assign new_a = q.alloc_entry[PREG_W-1:0];
  assign new_b = q.alloc_entry[2*PREG_W-1:PREG_W];

  // Source readiness of an incoming entry: preg 0, not busy, or written this cycle.
  assign cap_a = (new_a == '0) | ~q.busy[new_a] | (q.wakeup_flag & (q.wakeup_reg == new_a));
  assign cap_b = (new_b == '0) | ~q.busy[new_b] | (q.wakeup_flag & (q.wakeup_reg == new_b));

  // Per-slot wakeup match and the readiness the selector actually sees.
  always_comb begin
    wake_a = '0;
    wake_b = '0;
    eff_a  = '0;
    eff_b  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wake_a[i] = q.wakeup_flag & (entry_q[i][PREG_W-1:0] == q.wakeup_reg);
      wake_b[i] = q.wakeup_flag & (entry_q[i][2*PREG_W-1:PREG_W] == q.wakeup_reg);
`ifdef ISSUE_QUEUE_WAKEUP_BYPASS_EN
      eff_a[i]  = rdya_q[i] | wake_a[i];
      eff_b[i]  = rdyb_q[i] | wake_b[i];
`else
      eff_a[i]  = rdya_q[i];
      eff_b[i]  = rdyb_q[i];
`endif
    end
  end

  // Oldest-first select: scan downwards so the lowest ready index wins.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if ((CNT_W'(i) < count_q) && eff_a[i] && eff_b[i]) begin
        sel_vld = 1'b1;
        sel_idx = IDX_W'(i);
      end
    end
  end

  // Next state: flush, else wakeup, then issue with compaction, then append.
  always_comb begin
    entry_d       = entry_q;
    rdya_d        = rdya_q;
    rdyb_d        = rdyb_q;
    count_d       = count_q;
    issue_valid_d = 1'b0;
    issue_entry_d = issue_entry_q;
    overflow_d    = overflow_q;
    cnt_after     = count_q;
    if (q.FLUSH) begin
      count_d = '0;
      rdya_d  = '0;
      rdyb_d  = '0;
    end else begin
      rdya_d = rdya_q | wake_a;
      rdyb_d = rdyb_q | wake_b;
      if (!q.STALL) begin
        if (sel_vld) begin
          issue_entry_d = entry_q[sel_idx];
          issue_valid_d = 1'b1;
          for (int i = 0; i < DEPTH - 1; i++) begin
            if (i >= int'(sel_idx)) begin
              entry_d[i] = entry_q[i+1];
              rdya_d[i]  = rdya_q[i+1] | wake_a[i+1];
              rdyb_d[i]  = rdyb_q[i+1] | wake_b[i+1];
            end
          end
          cnt_after = count_q - CNT_W'(1);
        end
        count_d = cnt_after;
        if (q.alloc) begin
          if (cnt_after < FULL_CNT) begin
            for (int i = 0; i < DEPTH; i++) begin
              if (CNT_W'(i) == cnt_after) begin
                entry_d[i] = q.alloc_entry;
                rdya_d[i]  = cap_a;
                rdyb_d[i]  = cap_b;
              end
            end
            count_d = cnt_after + CNT_W'(1);
          end else begin
            overflow_d = 1'b1;
          end
        end
      end
    end
  end

  // State registers; RESET clears everything asynchronously.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      entry_q       <= '{default: '0};
      rdya_q        <= '0;
      rdyb_q        <= '0;
      count_q       <= '0;
      issue_valid_q <= 1'b0;
      issue_entry_q <= '0;
      overflow_q    <= 1'b0;
    end else begin
      entry_q       <= entry_d;
      rdya_q        <= rdya_d;
      rdyb_q        <= rdyb_d;
      count_q       <= count_d;
      issue_valid_q <= issue_valid_d;
      issue_entry_q <= issue_entry_d;
      overflow_q    <= overflow_d;
    end
  end

  assign q.issue_valid  = issue_valid_q;
  assign q.issue_entry  = issue_entry_q;
  assign q.count        = count_q;
  assign q.overflow_err = overflow_q;
  // One slot of margin because rename's allocate is registered.
  assign q.issue_halt   = (count_q >= HALT_CNT);
endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Out-of-order issue queue directly downstream of rename.
- Accepts renamed non-memory entries (89-bit format: instr[88:57], pc[56:25], control[24:18], MAPC[17:12], MAPB[11:6], MAPA[5:0]) and tracks readiness of source physical registers (MAPA, MAPB).
- Each cycle it issues the oldest ready entry to EXE.
- Drives issue_halt back to rename for back-pressure.

Parameters:
- DEPTH, 16, number of queue slots (power of two not required, >=2).
- ENTRY_W, 89, entry width.
- PREG_W, 6, physical register index width (64 pregs).

Ports:
- CLK  in  1  clock, posedge active.
- RESET  in  1  reset, asynchronous, active-low.
- STALL  in  1  freeze: no issue, no allocation; wakeups still applied.
- FLUSH  in  1  synchronous clear of all entries.
- alloc  in  1  entry_allocate_issue from rename.
- alloc_entry  in  ENTRY_W  entry_issue from rename.
- busy  in  64  rename busy vector; bit=1 means preg not yet written.
- wakeup_flag  in  1  EXE result broadcast valid.
- wakeup_reg  in  PREG_W  preg written by EXE.
- issue_halt  out  1  back-pressure to rename.
- issue_valid  out  1  one-cycle pulse, issue_entry valid.
- issue_entry  out  ENTRY_W  issued entry, unmodified.
- count  out  $clog2(DEPTH+1)  occupied slots.
- overflow_err  out  1  sticky: allocation arrived while full.

Behaviour:
- Reset (RESET=0, async): all slots invalid, count=0, issue_valid=0, issue_entry=0, overflow_err=0, issue_halt=0.
- Storage: compacting queue. Slots 0..count-1 are valid, slot 0 is oldest. Each slot holds the entry plus rdyA/rdyB bits.
- Ready capture on alloc: rdyX = (MAPX==0) | ~busy[MAPX] | (wakeup_flag & wakeup_reg==MAPX). Preg 0 is always ready.
- Wakeup: every edge with wakeup_flag=1 (including under STALL), every valid slot whose MAPA==wakeup_reg sets rdyA; same for MAPB/rdyB.
- Select: combinational. Picks the lowest-index valid slot with rdyA&rdyB, using the registered ready bits (see Optional Feature).
- Issue: at a posedge with STALL=0, FLUSH=0 and a selected slot k:
  - issue_entry<=slot k; issue_valid<=1.
  - Slots k+1..count-1 shift down by one.
  - Otherwise issue_valid<=0 and issue_entry holds its previous value.
- Alloc: at a posedge with alloc=1, STALL=0, FLUSH=0, the new entry is written to slot (count - issued), i.e. after compaction.
- Simultaneous issue+alloc: count unchanged. Allocation into a full queue is legal if an issue frees a slot in the same edge.
- Full: alloc=1 with count==DEPTH and no issue that edge drops the entry and sets overflow_err=1 until reset.
- issue_halt = (count >= DEPTH-1), combinational from count. The one-slot margin covers rename's registered allocate.
- Latency: an entry allocated at edge N that is ready at capture issues at edge N+1 at the earliest (issue_valid high after N+1).
- FLUSH (priority over alloc/issue/wakeup): at the next posedge all slots are invalidated, count=0, issue_valid=0. overflow_err is not cleared.
- STALL and FLUSH together: FLUSH wins.
- Reset asserted mid-operation clears everything immediately, regardless of CLK.
- Entries whose sources never wake remain resident. The queue never reorders except by compaction, so age order is preserved.

Optional Feature:
- Macro ISSUE_QUEUE_WAKEUP_BYPASS_EN.
- Defined: the select logic also ORs the current-cycle wakeup match into rdyA/rdyB. A slot that becomes ready by this cycle's wakeup_flag can issue at the same edge.
- Not defined: a wakeup only updates the ready bits, and the earliest issue is the following edge (one extra cycle of wakeup-to-issue latency).
- Both builds must pass the test plan, with latency expectations adjusted per macro.

Test Plan:
- Reset then single alloc: MAPA=3, MAPB=4, busy[3]=busy[4]=0 at edge 1 -> issue_valid=1 with identical entry after edge 2; count returns 0.
- Dependency wakeup: alloc with MAPA=10, busy[10]=1; wakeup_flag=1, wakeup_reg=10 at edge 5 -> issue at edge 6 without the macro, edge 5 with ISSUE_QUEUE_WAKEUP_BYPASS_EN.
- Age order: alloc A (not ready, MAPB=20 busy), then B and C (ready) -> B issues, then C. After wakeup of 20, A issues. Slot order stays A before later allocations.
- Fill: 15 allocs, none ready (DEPTH=16) -> issue_halt=1 at count=15. A 16th alloc succeeds (count=16). A 17th sets overflow_err=1 and count stays 16.
- Full with same-edge issue: count=16, one slot ready, alloc=1 -> entry accepted, count stays 16, overflow_err stays 0.
- FLUSH with 5 entries and alloc=1 the same edge -> count=0, issue_valid=0 next edge, new entry discarded. RESET low mid-cycle -> outputs zero immediately.
